writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 111 +++++++++++
 1 files changed

// File: rtl/writeback_queue.sv
// Four-entry register-file writeback queue with in-order draining and
// newest-wins forwarding of pending writes to two register-read lookups.
module writeback_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Wr_Valid_i,
  input  logic [4:0]   Wr_Register_i,
  input  logic [N-1:0] Wr_Data_i,
  output logic         Wr_Ready_o,
  input  logic         Drain_Stall_i,
  output logic         Reg_Write_o,
  output logic [4:0]   Write_Register_o,
  output logic [N-1:0] Write_Data_o,
  input  logic [4:0]   Lookup_Register_1_i,
  input  logic [4:0]   Lookup_Register_2_i,
  output logic         Fwd_Hit_1_o,
  output logic         Fwd_Hit_2_o,
  output logic [N-1:0] Fwd_Data_1_o,
  output logic [N-1:0] Fwd_Data_2_o,
  output logic [2:0]   Count_o
);

  localparam int PTR_W = 2;
  localparam int CNT_W = 3;
  localparam int NPORT = 2;

  logic [4:0]       r_reg  [DEPTH];
  logic [N-1:0]     r_data [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_empty;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  logic [4:0]       w_lookup [NPORT];

  assign w_empty = (r_count == '0);
  // Full queue refuses writes even when the head drains this same cycle.
  assign w_ready = (r_count < CNT_W'(DEPTH));
  assign w_pop   = !w_empty && !Drain_Stall_i;
  // Writes to register 0 complete the handshake but are dropped.
  assign w_push  = Wr_Valid_i && w_ready && (Wr_Register_i != 5'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_reg[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_reg[r_tail]  <= Wr_Register_i;
        r_data[r_tail] <= Wr_Data_i;
        r_tail         <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign Wr_Ready_o       = w_ready;
  assign Reg_Write_o      = w_pop;
  assign Write_Register_o = w_empty ? 5'd0 : r_reg[r_head];
  assign Write_Data_o     = w_empty ? '0   : r_data[r_head];
  assign Count_o          = r_count;

  assign w_lookup[0] = Lookup_Register_1_i;
  assign w_lookup[1] = Lookup_Register_2_i;

  // Scan oldest to newest so the last match (closest to tail) wins.
  // The head stays visible even while it is popped this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_fwd
      logic         w_hit;
      logic [N-1:0] w_fwd;

      always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        for (int k = 0; k < DEPTH; k++) begin
          if ((CNT_W'(k) < r_count) && (w_lookup[gi] != 5'd0) &&
              (r_reg[r_head + PTR_W'(k)] == w_lookup[gi])) begin
            w_hit = 1'b1;
            w_fwd = r_data[r_head + PTR_W'(k)];
          end
        end
      end
    end
  endgenerate

  assign Fwd_Hit_1_o  = g_fwd[0].w_hit;
  assign Fwd_Data_1_o = g_fwd[0].w_fwd;
  assign Fwd_Hit_2_o  = g_fwd[1].w_hit;
  assign Fwd_Data_2_o = g_fwd[1].w_fwd;

endmodule
